// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: the pipeline writeback has priority, and the accelerator
// gets a bounded-wait override. The grant is registered onto the write port one cycle later.
module wb_port_arbiter #(
    parameter int DATA_W   = 128,
    parameter int MAX_WAIT = 4,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              pipe_valid,
    input  logic [4:0]        pipe_rd,
    input  logic [DATA_W-1:0] pipe_data,
    output logic              pipe_ready,
    input  logic              acc_valid,
    input  logic [4:0]        acc_rd,
    input  logic [DATA_W-1:0] acc_data,
    output logic              acc_ready,
    output logic              rf_we,
    output logic [4:0]        rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [CNT_W-1:0]  conflict_cnt
);

    logic [3:0]        r_wait_cnt;
    logic [3:0]        w_wait_next;
    logic              r_rf_we;
    logic [4:0]        r_rf_waddr;
    logic [DATA_W-1:0] r_rf_wdata;
    logic [CNT_W-1:0]  r_conflict_cnt;

    logic w_starve;
    logic w_pipe_xfer;
    logic w_acc_xfer;
    logic w_conflict;

    // The ready terms look only at the other side's valid, so no combinational loop can form.
    assign w_starve    = (r_wait_cnt == 4'(MAX_WAIT));
    assign pipe_ready  = !(acc_valid && w_starve);
    assign acc_ready   = !pipe_valid || w_starve;
    assign w_pipe_xfer = pipe_valid && pipe_ready;
    assign w_acc_xfer  = acc_valid && acc_ready;
    assign w_conflict  = pipe_valid && acc_valid;

    always_comb begin
        w_wait_next = r_wait_cnt;
        if (!acc_valid || w_acc_xfer) begin
            w_wait_next = 4'd0;
        end else if (r_wait_cnt != 4'(MAX_WAIT)) begin
            w_wait_next = r_wait_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wait_cnt <= 4'd0;
        end else begin
            r_wait_cnt <= w_wait_next;
        end
    end

    // A request to rd 0 is still consumed; it only suppresses the write enable.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rf_we    <= 1'b0;
            r_rf_waddr <= 5'd0;
            r_rf_wdata <= '0;
        end else if (w_acc_xfer) begin
            r_rf_we    <= (acc_rd != 5'd0);
            r_rf_waddr <= acc_rd;
            r_rf_wdata <= acc_data;
        end else if (w_pipe_xfer) begin
            r_rf_we    <= (pipe_rd != 5'd0);
            r_rf_waddr <= pipe_rd;
            r_rf_wdata <= pipe_data;
        end else begin
            r_rf_we    <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_conflict_cnt <= '0;
        end else if (w_conflict && (r_conflict_cnt != {CNT_W{1'b1}})) begin
            r_conflict_cnt <= r_conflict_cnt + CNT_W'(1);
        end
    end

    assign rf_we        = r_rf_we;
    assign rf_waddr     = r_rf_waddr;
    assign rf_wdata     = r_rf_wdata;
    assign conflict_cnt = r_conflict_cnt;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed scenarios plus protocol-respecting random traffic,
// all checked against a cycle-level reference model of the arbitration rules.
module tb_wb_port_arbiter;

    localparam int DATA_W   = 128;
    localparam int MAX_WAIT = 4;
    localparam int CNT_W    = 16;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              pipe_valid = 1'b0;
    logic [4:0]        pipe_rd = '0;
    logic [DATA_W-1:0] pipe_data = '0;
    logic              pipe_ready;
    logic              acc_valid = 1'b0;
    logic [4:0]        acc_rd = '0;
    logic [DATA_W-1:0] acc_data = '0;
    logic              acc_ready;
    logic              rf_we;
    logic [4:0]        rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic [CNT_W-1:0]  conflict_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state: how long the accelerator has been kept waiting, the conflict
    // tally, and what the write port should show after the last edge.
    int                m_wait;
    int                m_cnt;
    logic              m_we;
    logic [4:0]        m_addr;
    logic [DATA_W-1:0] m_data;
    logic              m_pgrant;
    logic              m_agrant;

    wb_port_arbiter #(.DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .pipe_valid(pipe_valid), .pipe_rd(pipe_rd), .pipe_data(pipe_data), .pipe_ready(pipe_ready),
        .acc_valid(acc_valid), .acc_rd(acc_rd), .acc_data(acc_data), .acc_ready(acc_ready),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] rand_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic exp_pipe_ready();
        return !(acc_valid && (m_wait >= MAX_WAIT));
    endfunction

    function automatic logic exp_acc_ready();
        return !pipe_valid || (m_wait >= MAX_WAIT);
    endfunction

    task automatic model_reset();
        m_wait = 0; m_cnt = 0; m_we = 1'b0; m_addr = '0; m_data = '0;
        m_pgrant = 1'b0; m_agrant = 1'b0;
    endtask

    task automatic model_edge();
        logic starved;
        starved  = (m_wait >= MAX_WAIT);
        m_agrant = acc_valid && (!pipe_valid || starved);
        m_pgrant = pipe_valid && !m_agrant;
        if (m_agrant) begin
            m_we = (acc_rd != 0); m_addr = acc_rd; m_data = acc_data;
        end else if (m_pgrant) begin
            m_we = (pipe_rd != 0); m_addr = pipe_rd; m_data = pipe_data;
        end else begin
            m_we = 1'b0;
        end
        if (!acc_valid || m_agrant) m_wait = 0;
        else if (m_wait < MAX_WAIT) m_wait = m_wait + 1;
        if (pipe_valid && acc_valid && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
    endtask

    // Inputs only change 1ns after an edge, so their current values are the edge values.
    task automatic tick();
        if (reset_n) model_edge(); else model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; pipe_valid = 1'b1; pipe_rd = 5'd3; pipe_data = 128'hABCD;
        model_reset();
        tick(); tick();
        n_checks++; if (rf_we !== 1'b0) $display("FAIL reset_we got=%b want=0", rf_we); else n_pass++;
        n_checks++; if (conflict_cnt !== '0) $display("FAIL reset_cnt got=%0d want=0", conflict_cnt); else n_pass++;
        #2 reset_n = 1'b1;
        #1;
        n_checks++; if (rf_we !== 1'b0) $display("FAIL release_we got=%b want=0", rf_we); else n_pass++;
        n_checks++; if (pipe_ready !== 1'b1) $display("FAIL release_pready got=%b want=1", pipe_ready); else n_pass++;
        tick();
        n_checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd3)
            $display("FAIL first_write got we=%b addr=%0d want we=1 addr=3", rf_we, rf_waddr); else n_pass++;
        pipe_valid = 1'b0;
        $display("test_reset: first write rd=%0d", rf_waddr);
    endtask

    task automatic test_solo_pipe();
        pipe_valid = 1'b1; pipe_rd = 5'd5; pipe_data = 128'h1234;
        #1;
        n_checks++; if (pipe_ready !== 1'b1) $display("FAIL solo_pready got=%b want=1", pipe_ready); else n_pass++;
        tick();
        pipe_valid = 1'b0;
        n_checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 128'h1234)
            $display("FAIL solo_write got we=%b addr=%0d data=%h want we=1 addr=5 data=1234",
                     rf_we, rf_waddr, rf_wdata); else n_pass++;
        tick();
        n_checks++; if (rf_we !== 1'b0 || rf_waddr !== 5'd5)
            $display("FAIL solo_idle got we=%b addr=%0d want we=0 addr=5", rf_we, rf_waddr); else n_pass++;
        $display("test_solo_pipe: rd=5 data=%h", rf_wdata);
    endtask

    task automatic test_priority();
        pipe_valid = 1'b1; pipe_rd = 5'd1; pipe_data = 128'h11;
        acc_valid  = 1'b1; acc_rd  = 5'd2; acc_data  = 128'h22;
        for (int i = 0; i < 6; i++) begin
            logic want_pr;
            logic [4:0] want_addr;
            want_pr   = (i != 4);
            want_addr = want_pr ? 5'd1 : 5'd2;
            #1;
            n_checks++; if (pipe_ready !== want_pr || acc_ready !== !want_pr)
                $display("FAIL prio_ready cyc=%0d got p=%b a=%b want p=%b a=%b",
                         i, pipe_ready, acc_ready, want_pr, !want_pr); else n_pass++;
            tick();
            n_checks++; if (rf_we !== 1'b1 || rf_waddr !== want_addr)
                $display("FAIL prio_grant cyc=%0d got we=%b addr=%0d want addr=%0d",
                         i, rf_we, rf_waddr, want_addr); else n_pass++;
            if (i == 4) begin
                n_checks++; if (conflict_cnt !== CNT_W'(5))
                    $display("FAIL prio_cnt got=%0d want=5", conflict_cnt); else n_pass++;
            end
            $display("test_priority: cycle %0d granted rd=%0d", i, rf_waddr);
        end
        pipe_valid = 1'b0; acc_valid = 1'b0;
        tick();
    endtask

    task automatic test_rd_zero();
        acc_valid = 1'b1; acc_rd = 5'd0; acc_data = 128'h5A5A;
        #1;
        n_checks++; if (acc_ready !== 1'b1) $display("FAIL rd0_aready got=%b want=1", acc_ready); else n_pass++;
        tick();
        acc_valid = 1'b0;
        n_checks++; if (rf_we !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 128'h5A5A)
            $display("FAIL rd0_nowrite got we=%b addr=%0d data=%h want we=0 addr=0 data=5a5a",
                     rf_we, rf_waddr, rf_wdata); else n_pass++;
        $display("test_rd_zero: consumed, rf_we=%b", rf_we);
    endtask

    // Each requester keeps its request until the model says it was granted.
    task automatic test_random(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            if (!pipe_valid || m_pgrant) begin
                pipe_valid = ($urandom_range(0, 99) < 60);
                pipe_rd = 5'($urandom_range(0, 31)); pipe_data = rand_data();
            end
            if (!acc_valid || m_agrant) begin
                acc_valid = ($urandom_range(0, 99) < 50);
                acc_rd = 5'($urandom_range(0, 31)); acc_data = rand_data();
            end
            #1;
            n_checks++; if (pipe_ready !== exp_pipe_ready() || acc_ready !== exp_acc_ready())
                $display("FAIL rand_ready cyc=%0d got p=%b a=%b want p=%b a=%b", i,
                         pipe_ready, acc_ready, exp_pipe_ready(), exp_acc_ready()); else n_pass++;
            tick();
            n_checks++; if (rf_we !== m_we || rf_waddr !== m_addr || rf_wdata !== m_data)
                $display("FAIL rand_port cyc=%0d got we=%b addr=%0d data=%h want we=%b addr=%0d data=%h",
                         i, rf_we, rf_waddr, rf_wdata, m_we, m_addr, m_data); else n_pass++;
            n_checks++; if (conflict_cnt !== CNT_W'(m_cnt))
                $display("FAIL rand_cnt cyc=%0d got=%0d want=%0d", i, conflict_cnt, m_cnt); else n_pass++;
            if (m_pgrant || m_agrant)
                $display("test_random: cyc %0d %s rd=%0d we=%b", i, m_agrant ? "acc" : "pipe", m_addr, m_we);
        end
        // Both sides must drop only after acceptance, so step until any pending request clears.
        for (int i = 0; i < 16 && (pipe_valid || acc_valid); i++) begin
            if (m_pgrant) pipe_valid = 1'b0;
            if (m_agrant) acc_valid = 1'b0;
            if (pipe_valid || acc_valid) tick();
        end
        pipe_valid = 1'b0; acc_valid = 1'b0;
        tick();
    endtask

    task automatic test_async_reset();
        pipe_valid = 1'b1; pipe_rd = 5'd9;  pipe_data = 128'h99;
        acc_valid  = 1'b1; acc_rd  = 5'd10; acc_data  = 128'hAA;
        for (int i = 0; i < 3; i++) tick();
        n_checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd9)
            $display("FAIL async_pre got we=%b addr=%0d want we=1 addr=9", rf_we, rf_waddr); else n_pass++;
        #2 reset_n = 1'b0;
        model_reset();
        #1;
        n_checks++; if (rf_we !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== '0 || conflict_cnt !== '0)
            $display("FAIL async_clear got we=%b addr=%0d data=%h cnt=%0d want all zero",
                     rf_we, rf_waddr, rf_wdata, conflict_cnt); else n_pass++;
        tick();
        #2 reset_n = 1'b1;
        // A cleared wait count means the pipeline again gets MAX_WAIT grants before the accelerator.
        for (int i = 0; i < MAX_WAIT + 1; i++) begin
            logic want_pr;
            want_pr = (i < MAX_WAIT);
            #1;
            n_checks++; if (pipe_ready !== want_pr || acc_ready !== !want_pr)
                $display("FAIL async_wait cyc=%0d got p=%b a=%b want p=%b a=%b",
                         i, pipe_ready, acc_ready, want_pr, !want_pr); else n_pass++;
            tick();
            n_checks++; if (rf_waddr !== m_addr || rf_we !== m_we)
                $display("FAIL async_grant cyc=%0d got addr=%0d want addr=%0d", i, rf_waddr, m_addr); else n_pass++;
        end
        pipe_valid = 1'b0; acc_valid = 1'b0;
        tick();
        $display("test_async_reset: done, conflict_cnt=%0d", conflict_cnt);
    endtask

    task automatic test_saturation();
        pipe_valid = 1'b1; pipe_rd = 5'd4; pipe_data = 128'h44;
        acc_valid  = 1'b1; acc_rd  = 5'd6; acc_data  = 128'h66;
        for (int i = 0; i < (1 << CNT_W) + 3; i++) tick();
        n_checks++; if (conflict_cnt !== 16'hFFFF)
            $display("FAIL sat_cnt got=%h want=ffff", conflict_cnt); else n_pass++;
        n_checks++; if (conflict_cnt !== CNT_W'(m_cnt))
            $display("FAIL sat_model got=%0d want=%0d", conflict_cnt, m_cnt); else n_pass++;
        pipe_valid = 1'b0; acc_valid = 1'b0;
        tick();
        $display("test_saturation: conflict_cnt=%h", conflict_cnt);
    endtask

    initial begin
        #1;
        test_reset();
        test_solo_pipe();
        test_priority();
        test_rd_zero();
        test_random(400);
        test_async_reset();
        test_saturation();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
